wfg_drive_pat_seq: RTL and testbench

Sequencer for the pattern-driver channels. It owns the bit-period sub-cycle counter that every channel compares against its begin/end settings. It also consumes the AXI-Stream pattern words and presents one stable data word per bit period to all channels, using a one-entry prefetch buffer and underrun accounting. It sits between the stream source and the array of per-channel pattern drivers inside the drive_pat subsystem.

---
 rtl/wfg_drive_pat_seq.sv | 160 ++++++++++++++++
 tb/tb_wfg_drive_pat_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_drive_pat_seq.sv
// wfg_drive_pat_seq
// Pattern-driver sequencer: generates the bit-period sub-cycle counter shared by
// all channels and turns the AXI-Stream pattern words into one stable data word
// per bit period. A one-entry prefetch buffer decouples the stream from the
// period boundary; a period that starts with no new word repeats the previous
// word and is counted as an underrun.

module wfg_drive_pat_seq #(
  parameter int CHANNELS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_en_q_i,
  input  logic [7:0]          cfg_period_q_i,
  input  logic [CHANNELS-1:0] s_axis_tdata_i,
  input  logic                s_axis_tvalid_i,
  output logic                s_axis_tready_o,
  output logic [7:0]          pat_subcycle_cnt_o,
  output logic [CHANNELS-1:0] axis_data_o,
  output logic                ch_en_o,
  output logic                period_start_o,
  output logic                underrun_o,
  output logic [7:0]          underrun_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

  logic [1:0]          state_q;
  logic [7:0]          cnt_q;
  logic [CHANNELS-1:0] buf_q;
  logic                buf_valid_q;
  logic [CHANNELS-1:0] data_q;
  logic                underrun_q;
  logic [7:0]          underrun_cnt_q;

  logic in_idle;
  logic in_prime;
  logic in_run;
  logic ready;
  logic handshake;
  logic wrap;
  logic starve;

  // Decode state, stream acceptance and period-boundary events.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_idle   = 1'b0;
    in_prime  = 1'b0;
    in_run    = 1'b0;
    ready     = 1'b0;
    handshake = 1'b0;
    wrap      = 1'b0;
    starve    = 1'b0;

    in_idle   = (state_q == ST_IDLE);
    in_prime  = (state_q == ST_PRIME);
    in_run    = (state_q == ST_RUN);
    // Accept in PRIME, or in RUN while the prefetch slot is free.
    ready     = ctrl_en_q_i & (in_prime | (in_run & ~buf_valid_q));
    handshake = ready & s_axis_tvalid_i;
    // '>=' lets a shrunk period take effect on the very next cycle.
    wrap      = in_run & (cnt_q >= cfg_period_q_i);
    // Period boundary with neither a buffered nor a bypassed word available.
    starve    = ctrl_en_q_i & wrap & ~buf_valid_q & ~handshake;
  end

  // Sequencer state: IDLE -> PRIME on enable, PRIME -> RUN on first word, any -> IDLE on disable.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (!ctrl_en_q_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= ST_PRIME;
        ST_PRIME: if (handshake) state_q <= ST_RUN;
        ST_RUN:   state_q <= ST_RUN;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Sub-cycle counter: counts only in RUN, restarts at 0 on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (!ctrl_en_q_i || !in_run || wrap) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Prefetch buffer: filled by a mid-period handshake, drained at the next wrap.
  // NOTE: the buffer data is reset as well so axis_data_o can never pick up X, even though buf_valid_q guards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else if (!ctrl_en_q_i || !in_run) begin
      buf_valid_q <= 1'b0;
    end else if (wrap) begin
      buf_valid_q <= 1'b0;
    end else if (handshake) begin
      buf_q       <= s_axis_tdata_i;
      buf_valid_q <= 1'b1;
    end
  end

  // Current period data: loaded by the priming word, then at each wrap from buffer or bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (!ctrl_en_q_i || in_idle) begin
      data_q <= '0;
    end else if (in_prime) begin
      if (handshake) data_q <= s_axis_tdata_i;
    end else if (wrap) begin
      if (buf_valid_q) begin
        data_q <= buf_q;
      end else if (handshake) begin
        data_q <= s_axis_tdata_i;
      end
    end
  end

  // Underrun flag for the first cycle of a repeated period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= starve;
    end
  end

  // Saturating underrun counter: cleared when a new run is armed, kept across disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= 8'd0;
    end else if (ctrl_en_q_i && in_idle) begin
      underrun_cnt_q <= 8'd0;
    end else if (starve && (underrun_cnt_q != UNDERRUN_MAX)) begin
      underrun_cnt_q <= underrun_cnt_q + 8'd1;
    end
  end

  assign s_axis_tready_o    = ready;
  assign pat_subcycle_cnt_o = cnt_q;
  assign axis_data_o        = data_q;
  assign ch_en_o            = in_run;
  assign period_start_o     = in_run & (cnt_q == 8'd0);
  assign underrun_o         = underrun_q;
  assign underrun_cnt_o     = underrun_cnt_q;

endmodule

// File: tb/tb_wfg_drive_pat_seq.sv
// Testbench for wfg_drive_pat_seq: randomized and directed stimulus, a
// behavioural reference model of the sequencer, and a scoreboard of expected
// period-start words consumed by a monitor whenever the DUT signals a period start.

module tb_wfg_drive_pat_seq;

  localparam int CH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    period = 8'd0;
  logic [CH-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [7:0]    cnt;
  logic [CH-1:0] data;
  logic          ch_en;
  logic          pstart;
  logic          urun_o;
  logic [7:0]    ucnt_o;

  wfg_drive_pat_seq #(.CHANNELS(CH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ctrl_en_q_i        (en),
    .cfg_period_q_i     (period),
    .s_axis_tdata_i     (tdata),
    .s_axis_tvalid_i    (tvalid),
    .s_axis_tready_o    (tready),
    .pat_subcycle_cnt_o (cnt),
    .axis_data_o        (data),
    .ch_en_o            (ch_en),
    .period_start_o     (pstart),
    .underrun_o         (urun_o),
    .underrun_cnt_o     (ucnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PRIME, M_RUN} mode_t;
  typedef struct packed {
    logic [CH-1:0] word;
    logic          urun;
    logic [7:0]    ucnt;
  } exp_t;

  mode_t         mode = M_IDLE;
  int            phase = 0;
  logic [CH-1:0] cur = '0;
  logic [CH-1:0] pend[$];
  int            ucnt = 0;
  bit            urun = 1'b0;
  bit            take;
  exp_t          exp_q[$];

  function automatic bit m_ready();
    return en && (mode == M_PRIME || (mode == M_RUN && pend.size() == 0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_IDLE; phase = 0; cur = '0; ucnt = 0; urun = 1'b0;
      pend.delete();
      exp_q.delete();
    end else begin
      take = m_ready() && tvalid;
      urun = 1'b0;
      if (!en) begin
        mode = M_IDLE; phase = 0; cur = '0;
        pend.delete();
      end else begin
        case (mode)
          M_IDLE: begin mode = M_PRIME; ucnt = 0; end
          M_PRIME: if (take) begin mode = M_RUN; phase = 0; cur = tdata; end
          M_RUN: begin
            if (phase >= int'(period)) begin
              phase = 0;
              if (pend.size() != 0) cur = pend.pop_front();
              else if (take) cur = tdata;
              else begin
                urun = 1'b1;
                if (ucnt < 255) ucnt++;
              end
            end else begin
              phase++;
              if (take) pend.push_back(tdata);
            end
          end
          default: mode = M_IDLE;
        endcase
      end
      if (mode == M_RUN && phase == 0) exp_q.push_back('{word: cur, urun: urun, ucnt: 8'(ucnt)});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] a, e;
    exp_t x;
    a = {12'b0, tready, cnt, ch_en, pstart, urun_o, ucnt_o, data};
    e = {12'b0, m_ready(), 8'(phase), mode == M_RUN, (mode == M_RUN && phase == 0),
         urun, 8'(ucnt), cur};
    check("cycle_outputs", a, e);
    if (pstart === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_period_start", 64'd1, 64'd0);
      end else begin
        x = exp_q.pop_front();
        check("sb_period_word", {31'b0, urun_o, ucnt_o, data}, {31'b0, x.urun, x.ucnt, x.word});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    while (cnt !== v && n < 100) begin
      tick();
      n++;
    end
    check("wait_cnt_timeout", 64'(n < 100), 64'd1);
  endtask

  initial begin
    logic [CH-1:0] w;
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {tready, cnt, ch_en, pstart, urun_o, ucnt_o, data}, '0);
    rst_n = 1'b1;
    tick();

    // Prime
    en = 1'b1; period = 8'd3; tvalid = 1'b0;
    tick();
    #1 check("prime_tready_1", 64'(tready), 64'd1);
    tick();
    #1 check("prime_tready_2", 64'(tready), 64'd1);
    tvalid = 1'b1; tdata = 32'hA5A5_0001;
    #1 check("prime_tready_3", 64'(tready), 64'd1);
    tick();
    check("prime_run", {ch_en, pstart, cnt, data}, {1'b1, 1'b1, 8'd0, 32'hA5A5_0001});

    // Steady stream, period 3
    for (int i = 0; i < 40; i++) begin
      tdata = $urandom;
      tick();
    end

    // Bypass: one word per clock
    period = 8'd0;
    w = 32'h1000_0000;
    for (int i = 0; i < 20; i++) begin
      tdata = w;
      #1 check("bypass_tready", 64'(tready), 64'd1);
      tick();
      check("bypass_data", 64'(data), 64'(w));
      w = w + 1;
    end

    // Underrun to saturation
    tvalid = 1'b0; period = 8'd3;
    repeat (260 * 4) tick();
    check("underrun_saturated", 64'(ucnt_o), 64'd255);

    // Period shrink 9 -> 2 at cnt 6
    period = 8'd9;
    wait_cnt(8'd6);
    period = 8'd2;
    tick();
    check("shrink_cnt", 64'(cnt), 64'd0);

    // Disable with a buffered word, then re-enable
    period = 8'd5;
    wait_cnt(8'd1);
    tvalid = 1'b1; tdata = 32'hDEAD_BEEF;
    tick();
    tvalid = 1'b0; en = 1'b0;
    #1 check("disable_tready", 64'(tready), 64'd0);
    tick();
    check("disable_idle", {tready, cnt, ch_en, pstart, urun_o, data}, '0);
    check("disable_keep_ucnt", 64'(ucnt_o), 64'd255);
    en = 1'b1;
    tick();
    check("reenable_ucnt_clear", 64'(ucnt_o), 64'd0);
    tvalid = 1'b1; tdata = 32'h1234_5678;
    tick();
    check("reenable_no_replay", 64'(data), 64'h1234_5678);

    // Randomized operation
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) period = 8'($urandom_range(0, 5));
      en = ($urandom_range(0, 60) != 0);
      tvalid = $urandom_range(0, 1);
      tdata = $urandom;
      tick();
    end

    // Asynchronous reset mid-run
    en = 1'b1; tvalid = 1'b1; period = 8'd2;
    repeat (6) tick();
    rst_n = 1'b0;
    #1 check("async_reset", {tready, cnt, ch_en, pstart, urun_o, ucnt_o, data}, '0);
    tick();
    check("reset_no_accept", 64'(tready), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tvalid = $urandom_range(0, 1);
      tdata = $urandom;
      tick();
    end

    @(negedge clk);
    #1 check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
